// File: rtl/cochlea_seq_ctrl.sv
// Sequencer for the wrapper-cell filter-bank chain: chain reset, adaptation window,
// then tagged event capture from the shared readout bus into a valid/ready FIFO.
module cochlea_seq_ctrl #(
  parameter int unsigned N_CH       = 16,
  parameter int unsigned CH_W       = 4,
  parameter int unsigned ADAPT_W    = 16,
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk_master,
  input  logic               rstb,
  input  logic               start,
  input  logic               stop,
  input  logic               readapt,
  input  logic [ADAPT_W-1:0] adapt_len,
  input  logic [1:0]         read_out_I,
  input  logic [1:0]         read_out_Q,
  output logic               chain_rstb,
  output logic               ud_en,
  output logic [1:0]         state,
  output logic [CH_W+3:0]    ro_data,
  output logic               ro_valid,
  input  logic               ro_ready,
  output logic               overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = CH_W + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RESET = 2'b01,
    S_ADAPT = 2'b10,
    S_RUN   = 2'b11
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ADAPT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CH_W-1:0]    r_chan, w_chan_nxt;
  logic               r_chain_rstb, w_chain_rstb_nxt;
  logic               r_ud_en, w_ud_en_nxt;
  logic               w_start_acc;

  logic [DW-1:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]        r_wr, r_rd, w_wr_nxt, w_rd_nxt;
  logic [DW-1:0]      r_head, w_head_nxt, w_push_data;
  logic               r_valid, r_ovf;
  logic               w_pop, w_push_req, w_push, w_drop, w_full;

  // Next-state and registered-output decode; stop overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_chan_nxt  = r_chan;
    w_start_acc = 1'b0;
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_chan_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_RESET;
            w_cnt_nxt   = ADAPT_W'(RST_CYCLES);
            w_start_acc = 1'b1;
          end
        end
        S_RESET: begin
          if (r_cnt <= ADAPT_W'(1)) begin
            if (adapt_len != '0) begin
              w_state_nxt = S_ADAPT;
              w_cnt_nxt   = adapt_len;
            end else begin
              w_state_nxt = S_RUN;
              w_cnt_nxt   = '0;
              w_chan_nxt  = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt - ADAPT_W'(1);
          end
        end
        S_ADAPT: begin
          if (r_cnt <= ADAPT_W'(1)) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_chan_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt - ADAPT_W'(1);
          end
        end
        S_RUN: begin
          w_chan_nxt = (r_chan == CH_W'(N_CH - 1)) ? '0 : r_chan + CH_W'(1);
          if (readapt && (adapt_len != '0)) begin
            w_state_nxt = S_ADAPT;
            w_cnt_nxt   = adapt_len;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_chain_rstb_nxt = (w_state_nxt == S_ADAPT) || (w_state_nxt == S_RUN);
    w_ud_en_nxt      = (w_state_nxt == S_ADAPT);
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_chan       <= '0;
      r_chain_rstb <= 1'b0;
      r_ud_en      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_chan       <= w_chan_nxt;
      r_chain_rstb <= w_chain_rstb_nxt;
      r_ud_en      <= w_ud_en_nxt;
    end
  end

  // FIFO control; a full FIFO still accepts a push when the head leaves this cycle
  always_comb begin
    w_full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    w_pop       = r_valid && ro_ready && !stop;
    w_push_req  = (r_state == S_RUN) && !stop && ((read_out_I | read_out_Q) != 2'b00);
    w_push      = w_push_req && (!w_full || w_pop);
    w_drop      = w_push_req && w_full && !w_pop;
    w_push_data = {r_chan, read_out_Q, read_out_I};
    w_wr_nxt    = stop ? '0 : r_wr + (AW+1)'(w_push);
    w_rd_nxt    = stop ? '0 : r_rd + (AW+1)'(w_pop);
    if (w_wr_nxt == w_rd_nxt)
      w_head_nxt = '0;
    else if (w_push && (w_rd_nxt == r_wr))
      w_head_nxt = w_push_data;
    else
      w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      r_mem   <= '{default: '0};
      r_wr    <= '0;
      r_rd    <= '0;
      r_head  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push)
        r_mem[r_wr[AW-1:0]] <= w_push_data;
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_head  <= w_head_nxt;
      r_valid <= (w_wr_nxt != w_rd_nxt);
      if (w_start_acc)
        r_ovf <= 1'b0;
      else if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign state      = r_state;
  assign chain_rstb = r_chain_rstb;
  assign ud_en      = r_ud_en;
  assign ro_data    = r_head;
  assign ro_valid   = r_valid;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_cochlea_seq_ctrl.sv
// Bench for cochlea_seq_ctrl: directed scenarios plus randomized traffic against
// a queue-based behavioural model of the sequencer and event FIFO.
module tb_cochlea_seq_ctrl;

  localparam int unsigned N_CH       = 16;
  localparam int unsigned CH_W       = 4;
  localparam int unsigned ADAPT_W    = 16;
  localparam int unsigned RST_CYCLES = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DW         = CH_W + 4;

  logic               clk_master = 1'b0;
  logic               rstb       = 1'b0;
  logic               start      = 1'b0;
  logic               stop       = 1'b0;
  logic               readapt    = 1'b0;
  logic               ro_ready   = 1'b0;
  logic [ADAPT_W-1:0] adapt_len  = '0;
  logic [1:0]         read_out_I = 2'b00;
  logic [1:0]         read_out_Q = 2'b00;
  logic               chain_rstb, ud_en, ro_valid, overflow;
  logic [1:0]         state;
  logic [DW-1:0]      ro_data;

  int n_checks = 0;
  int n_pass   = 0;

  cochlea_seq_ctrl #(
    .N_CH(N_CH), .CH_W(CH_W), .ADAPT_W(ADAPT_W),
    .RST_CYCLES(RST_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_master(clk_master), .rstb(rstb), .start(start), .stop(stop),
    .readapt(readapt), .adapt_len(adapt_len), .read_out_I(read_out_I),
    .read_out_Q(read_out_Q), .chain_rstb(chain_rstb), .ud_en(ud_en),
    .state(state), .ro_data(ro_data), .ro_valid(ro_valid),
    .ro_ready(ro_ready), .overflow(overflow)
  );

  always #5 clk_master = ~clk_master;

  wire [DW+5:0] w_obs = {state, chain_rstb, ud_en, ro_valid, ro_data, overflow};

  // Behavioural model: phase number, cycles left in phase, cycles spent in RUN, event queue
  int            m_state, m_left, m_run;
  logic          m_ovf;
  logic [DW-1:0] m_q[$];

  function automatic logic [DW+5:0] exp_vec();
    logic          v;
    logic [DW-1:0] d;
    v = (m_q.size() > 0);
    d = v ? m_q[0] : '0;
    return {2'(m_state), (m_state >= 2), (m_state == 2), v, d, m_ovf};
  endfunction

  task automatic model_reset();
    m_state = 0; m_left = 0; m_run = 0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic pop;
    pop = (m_q.size() > 0) && ro_ready;
    if (stop) begin
      m_state = 0;
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      case (m_state)
        0: if (start) begin m_state = 1; m_left = RST_CYCLES; m_ovf = 1'b0; end
        1: begin
          m_left--;
          if (m_left == 0) begin
            if (adapt_len != 0) begin m_state = 2; m_left = int'(adapt_len); end
            else begin m_state = 3; m_run = 0; end
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin m_state = 3; m_run = 0; end
        end
        default: begin
          if ((read_out_I | read_out_Q) != 2'b00) begin
            if (m_q.size() < FIFO_DEPTH)
              m_q.push_back({CH_W'(m_run % N_CH), read_out_Q, read_out_I});
            else
              m_ovf = 1'b1;
          end
          m_run++;
          if (readapt && adapt_len != 0) begin m_state = 2; m_left = int'(adapt_len); end
        end
      endcase
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs sampled 1 time unit later
  task automatic tick();
    model_step();
    @(posedge clk_master);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #2;
    model_reset();
    n_checks++;
    if (w_obs !== exp_vec())
      $display("FAIL reset_values: got %h want %h", w_obs, exp_vec());
    else n_pass++;
    @(posedge clk_master);
    #1;
    rstb = 1'b1;
  endtask

  task automatic test_adapt_window();
    int rst_low = 0, ud_hi = 0;
    adapt_len = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!chain_rstb) rst_low++;
      if (ud_en) ud_hi++;
      n_checks++;
      if (w_obs !== exp_vec())
        $display("FAIL adapt_trace cyc %0d: got %h want %h", i, w_obs, exp_vec());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (rst_low !== 8) $display("FAIL chain_rstb_low_cycles: got %0d want 8", rst_low);
    else n_pass++;
    n_checks++;
    if (ud_hi !== 5) $display("FAIL ud_en_high_cycles: got %0d want 5", ud_hi);
    else n_pass++;
    n_checks++;
    if ({state, ud_en} !== 3'b110) $display("FAIL run_after_adapt: got %b want 110", {state, ud_en});
    else n_pass++;
  endtask

  task automatic test_skip_adapt();
    int ud_hi = 0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    adapt_len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ud_en) ud_hi++;
      n_checks++;
      if (w_obs !== exp_vec())
        $display("FAIL skip_trace cyc %0d: got %h want %h", i, w_obs, exp_vec());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (ud_hi !== 0) $display("FAIL skip_ud_en: got %0d high cycles want 0", ud_hi);
    else n_pass++;
    n_checks++;
    if (state !== 2'b11) $display("FAIL skip_state: got %b want 11", state);
    else n_pass++;
  endtask

  task automatic restart_to_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    adapt_len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && state != 2'b11; i++) tick();
    n_checks++;
    if (state !== 2'b11) $display("FAIL reach_run: got %b want 11", state);
    else n_pass++;
  endtask

  task automatic test_capture_wrap();
    ro_ready = 1'b1;
    restart_to_run();
    for (int c = 0; c < 20; c++) begin
      read_out_I = (c == 3)  ? 2'b01 : 2'b00;
      read_out_Q = (c == 18) ? 2'b10 : 2'b00;
      tick();
      read_out_I = 2'b00;
      read_out_Q = 2'b00;
      if (c == 3) begin
        n_checks++;
        if ({ro_valid, ro_data} !== {1'b1, 8'h31})
          $display("FAIL capture_chan3: got %b/%h want 1/31", ro_valid, ro_data);
        else n_pass++;
      end
      if (c == 18) begin
        n_checks++;
        if ({ro_valid, ro_data} !== {1'b1, 8'h28})
          $display("FAIL capture_wrap_chan2: got %b/%h want 1/28", ro_valid, ro_data);
        else n_pass++;
      end
      n_checks++;
      if (w_obs !== exp_vec())
        $display("FAIL capture_trace cyc %0d: got %h want %h", c, w_obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_e[5];
    ro_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      read_out_I = 2'($urandom_range(1, 3));
      read_out_Q = 2'($urandom);
      exp_e[i] = {CH_W'(m_run % N_CH), read_out_Q, read_out_I};
      tick();
    end
    read_out_I = 2'b00;
    read_out_Q = 2'b00;
    n_checks++;
    if ({ro_valid, overflow} !== 2'b11) $display("FAIL overflow_set: got %b want 11", {ro_valid, overflow});
    else n_pass++;
    ro_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({ro_valid, ro_data} !== {1'b1, exp_e[i]})
        $display("FAIL drain_%0d: got %b/%h want 1/%h", i, ro_valid, ro_data, exp_e[i]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({ro_valid, ro_data, overflow} !== {1'b0, 8'h00, 1'b1})
      $display("FAIL drain_empty: got %b/%h/%b want 0/00/1", ro_valid, ro_data, overflow);
    else n_pass++;
  endtask

  task automatic test_back_to_back_full();
    int pops = 0;
    restart_to_run();
    ro_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_out_I = 2'($urandom_range(1, 3));
      tick();
    end
    read_out_I = 2'b11;
    ro_ready = 1'b1;
    tick();
    read_out_I = 2'b00;
    n_checks++;
    if ({ro_valid, overflow} !== 2'b10) $display("FAIL full_push_pop: got %b want 10", {ro_valid, overflow});
    else n_pass++;
    for (int i = 0; i < 10 && ro_valid; i++) begin
      pops++;
      tick();
    end
    n_checks++;
    if (pops !== 4) $display("FAIL full_push_pop_count: got %0d want 4", pops);
    else n_pass++;
    n_checks++;
    if (w_obs !== exp_vec()) $display("FAIL full_trace: got %h want %h", w_obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_readapt();
    int ud_hi = 0, rst_low = 0;
    adapt_len = 16'd3;
    readapt = 1'b1;
    tick();
    readapt = 1'b0;
    adapt_len = 16'($urandom_range(7, 20));
    for (int i = 0; i < 3; i++) begin
      if (ud_en) ud_hi++;
      if (!chain_rstb) rst_low++;
      tick();
    end
    n_checks++;
    if ({ud_hi, rst_low} !== {32'd3, 32'd0})
      $display("FAIL readapt_window: got ud %0d low %0d want 3/0", ud_hi, rst_low);
    else n_pass++;
    n_checks++;
    if ({state, ud_en, chain_rstb} !== 4'b1101) $display("FAIL readapt_run: got %b want 1101", {state, ud_en, chain_rstb});
    else n_pass++;
    read_out_I = 2'b10;
    tick();
    read_out_I = 2'b00;
    n_checks++;
    if ({ro_valid, ro_data} !== {1'b1, 8'h02}) $display("FAIL readapt_chan0: got %b/%h want 1/02", ro_valid, ro_data);
    else n_pass++;
    adapt_len = 16'd6;
    readapt = 1'b1;
    tick();
    readapt = 1'b0;
    tick();
    tick();
    n_checks++;
    if (state !== 2'b10) $display("FAIL in_adapt: got %b want 10", state);
    else n_pass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if ({state, ud_en, chain_rstb, ro_valid} !== 5'b00000)
      $display("FAIL stop_mid_adapt: got %b want 00000", {state, ud_en, chain_rstb, ro_valid});
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (state !== 2'b10) $display("FAIL adapt_before_rstb: got %b want 10", state);
    else n_pass++;
    test_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      stop       = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 7) == 0);
      readapt    = ($urandom_range(0, 31) == 0);
      adapt_len  = 16'($urandom_range(0, 6));
      read_out_I = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      read_out_Q = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      ro_ready   = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (w_obs !== exp_vec())
        $display("FAIL random cyc %0d: got %h want %h", i, w_obs, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_adapt_window();
    test_skip_adapt();
    test_capture_wrap();
    test_overflow();
    test_back_to_back_full();
    restart_to_run();
    ro_ready = 1'b1;
    test_readapt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
